// File: rtl/init_pkg.sv
// Shared types for the multi-channel S-array initialiser: pattern modes and FSM states.
package init_pkg;

  typedef enum logic [1:0] {
    INIT_IDENT = 2'b00,
    INIT_FILL  = 2'b01,
    INIT_REV   = 2'b10
  } init_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DONE
  } init_state_t;

endpackage

// File: rtl/init_pattern.sv
// Combinational pattern generator: maps the sweep index to the word written at that address.
module init_pattern
  import init_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic [1:0]        mode_q,
  input  logic [DATA_W-1:0] fill_q,
  input  logic [ADDR_W-1:0] idx,
  output logic [DATA_W-1:0] wrdata
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] pat;

  always_comb begin
    pat = idx;
    if (mode_q == INIT_REV) pat = LAST - idx;
    // The cast zero-extends or truncates the index-derived value to the data width.
    wrdata = DATA_W'(pat);
    if (mode_q == INIT_FILL) wrdata = fill_q;
  end

endmodule

// File: rtl/init_multi.sv
// Multi-channel memory initialiser: sweeps addresses 0..DEPTH-1 writing a latched pattern to masked channels.
// Start handshake: a run starts on a rising edge where en=1 and rdy=1; en at any other time is dropped.
module init_multi
  import init_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_val,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              stall,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic [NUM_CH-1:0] wren,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  init_state_t       state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] pat_data;

  init_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_pattern (
    .mode_q (mode_q),
    .fill_q (fill_q),
    .idx    (i_q),
    .wrdata (pat_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      mode_q  <= '0;
      fill_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    mask_d  = mask_q;
    rdy     = 1'b0;
    done    = 1'b0;
    wren    = '0;
    addr    = '0;
    wrdata  = '0;
    case (state_q)
      ST_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          mode_d  = mode;
          fill_d  = fill_val;
          mask_d  = ch_mask;
          i_d     = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr   = i_q;
        wrdata = pat_data;
        // Abort beats stall: the run is dropped without writing this cycle.
        if (abort) begin
          i_d     = '0;
          state_d = ST_IDLE;
        end else if (!stall) begin
          wren = mask_q;
          if (i_q == LAST) state_d = ST_DONE;
          else             i_d     = i_q + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_init_multi.sv
// Self-checking bench for init_multi: randomized runs scored against a reference write list per run.
module tb_init_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, stall, abort, rdy, done;
  logic [1:0] mode, ch_mask, wren;
  logic [7:0] fill_val, addr, wrdata;

  logic       en_s, stall_s, abort_s, rdy_s, done_s;
  logic [1:0] mode_s, mask_s, wren_s;
  logic [3:0] fill_s, addr_s, wrdata_s;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  init_multi u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .mode(mode), .fill_val(fill_val),
    .ch_mask(ch_mask), .stall(stall), .abort(abort), .addr(addr), .wrdata(wrdata),
    .wren(wren), .done(done)
  );

  init_multi #(.ADDR_W(4), .DATA_W(4), .DEPTH(16), .NUM_CH(2)) u_small (
    .clk(clk), .rst_n(rst_n), .en(en_s), .rdy(rdy_s), .mode(mode_s), .fill_val(fill_s),
    .ch_mask(mask_s), .stall(stall_s), .abort(abort_s), .addr(addr_s), .wrdata(wrdata_s),
    .wren(wren_s), .done(done_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Word the memory should hold at address k after a run in mode m.
  function automatic logic [7:0] ref_data(input logic [1:0] m, input logic [7:0] f, input int k);
    case (m)
      2'b01:   return f;
      2'b10:   return 8'(255 - k);
      default: return 8'(k);
    endcase
  endfunction

  task automatic run(input logic [1:0] m, input logic [7:0] f, input logic [1:0] msk,
                     input int stall_pct, input int stall_at, input int stall_len,
                     input int abort_at, input bit mess);
    int k, edges, stalls, stall_left;
    bit st, ab, stall_used;
    logic [7:0] e;
    exp_q.delete();
    for (int j = 0; j < 256; j++) exp_q.push_back(ref_data(m, f, j));
    @(posedge clk); #1;
    mode = m; fill_val = f; ch_mask = msk; en = 1'b1;
    abort = 1'($urandom_range(0, 1));
    stall = 1'b0;
    @(negedge clk);
    check("idle_rdy", rdy, 1);
    @(posedge clk); #1;
    en = 1'b0; abort = 1'b0;
    k = 0; edges = 0; stalls = 0; stall_left = 0; stall_used = 1'b0;
    while (k < 256) begin
      if (mess) begin
        en = 1'($urandom_range(0, 1));
        mode = 2'($urandom); ch_mask = 2'($urandom); fill_val = 8'($urandom);
      end
      if (k == stall_at && !stall_used) begin
        stall_left = stall_len;
        stall_used = 1'b1;
      end
      st = (stall_left > 0) || ($urandom_range(1, 100) <= stall_pct);
      if (stall_left > 0) stall_left--;
      ab = (k == abort_at);
      stall = st; abort = ab;
      @(negedge clk);
      check("run_rdy", rdy, 0);
      check("run_done", done, 0);
      check("addr", addr, k);
      if (ab) begin
        check("abort_wren", wren, 0);
        @(posedge clk); #1;
        abort = 1'b0; stall = 1'b0; en = 1'b0;
        @(negedge clk);
        check("abort_rdy", rdy, 1);
        check("abort_done", done, 0);
        check("abort_wren_idle", wren, 0);
        return;
      end
      if (!st) begin
        e = exp_q.pop_front();
        check("wrdata", wrdata, e);
        check("wren", wren, msk);
        k++;
      end else begin
        check("stall_wren", wren, 0);
        check("stall_data", wrdata, exp_q[0]);
        stalls++;
      end
      @(posedge clk); #1;
      edges++;
    end
    stall = 1'b0; en = 1'b0;
    abort = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("done_pulse", done, 1);
    check("done_rdy", rdy, 0);
    check("done_wren", wren, 0);
    check("latency", edges, 256 + stalls);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("post_rdy", rdy, 1);
    check("post_done", done, 0);
  endtask

  task automatic reset_mid();
    @(posedge clk); #1;
    mode = 2'b00; ch_mask = 2'b11; en = 1'b1; stall = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("rst_pre_addr", addr, 50);
    rst_n = 1'b0;
    #1;
    check("rst_wren", wren, 0);
    check("rst_rdy", rdy, 1);
    check("rst_addr", addr, 0);
    check("rst_done", done, 0);
    check("rst_wrdata", wrdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_no_resume_rdy", rdy, 1);
    check("rst_no_resume_wren", wren, 0);
  endtask

  task automatic run_small(input logic [1:0] m);
    int edges;
    @(posedge clk); #1;
    mode_s = m; mask_s = 2'b11; en_s = 1'b1;
    @(posedge clk); #1;
    en_s = 1'b0;
    edges = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("s_addr", addr_s, k);
      check("s_wrdata", wrdata_s, (m == 2'b10) ? 15 - k : k);
      check("s_wren", wren_s, 2'b11);
      @(posedge clk); #1;
      edges++;
    end
    @(negedge clk);
    check("s_done", done_s, 1);
    check("s_latency", edges, 16);
    @(posedge clk); #1;
    @(negedge clk);
    check("s_rdy", rdy_s, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; stall = 1'b0; abort = 1'b0; mode = 2'b00; ch_mask = 2'b00; fill_val = 8'h00;
    en_s = 1'b0; stall_s = 1'b0; abort_s = 1'b0; mode_s = 2'b00; mask_s = 2'b00; fill_s = 4'h0;
    #1;
    check("reset_rdy", rdy, 1);
    check("reset_wren", wren, 0);
    check("reset_done", done, 0);
    check("reset_addr", addr, 0);
    check("reset_wrdata", wrdata, 0);
    check("reset_small_rdy", rdy_s, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(2'b00, 8'h00, 2'b11, 0, -1, 0, -1, 1'b0);
    run(2'b10, 8'h00, 2'b01, 0, -1, 0, -1, 1'b0);
    run(2'b01, 8'hA5, 2'b11, 0, 10, 3, -1, 1'b0);
    run(2'b00, 8'h00, 2'b11, 0, -1, 0, 100, 1'b0);
    run(2'b00, 8'h00, 2'b10, 0, -1, 0, -1, 1'b0);
    run(2'b10, 8'h3C, 2'b11, 10, -1, 0, -1, 1'b1);
    run(2'b01, 8'($urandom), 2'b00, 15, -1, 0, -1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      run(2'($urandom), 8'($urandom), 2'($urandom), $urandom_range(0, 20),
          $urandom_range(0, 255), $urandom_range(1, 4),
          ($urandom_range(0, 1) == 1) ? $urandom_range(0, 255) : -1, 1'($urandom_range(0, 1)));
    end
    run(2'b11, 8'h00, 2'b11, 5, -1, 0, -1, 1'b0);
    reset_mid();
    run_small(2'b00);
    run_small(2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
